// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic pipeline-stage register placed between two MIPS pipeline stages
// (IF/ID, ID/EXE, EXE/MEM, MEM/WB). It replaces a fixed-field stage latch with
// a control slice and a data slice that move together under a valid/ready
// handshake.
//
// Behaviour summary:
//   - One-cycle latency. Full throughput while out_ready is high.
//   - SKID_EN=1: a second (skid) entry absorbs one beat when the downstream
//     stalls, so in_ready is a plain register with no path from out_ready.
//   - SKID_EN=0: single entry, in_ready = !out_valid || out_ready.
//   - flush empties every held beat and drops any beat offered that cycle.
//   - The control slice is zero whenever out_valid is low, so a bubble can
//     never carry MemWrite/RegWrite downstream. The data slice keeps its
//     last value in a bubble.
//   - stall_cnt counts cycles with out_valid && !out_ready and saturates.
//
// Parameters:
//   CTRL_W   width of the control slice
//   DATA_W   width of the data slice
//   SKID_EN  1 = two entries with registered in_ready, 0 = single entry
//   COUNT_W  width of the saturating stall counter
//
// Ports:
//   clk        in   clock, all state on the rising edge
//   rst        in   synchronous reset, active low
//   in_valid   in   upstream beat valid
//   in_ready   out  stage can accept a beat
//   in_ctrl    in   upstream control slice
//   in_data    in   upstream data slice
//   out_valid  out  output beat valid
//   out_ready  in   downstream accepts the beat
//   out_ctrl   out  registered control slice, zero when out_valid is low
//   out_data   out  registered data slice
//   flush      in   discard all held beats and the beat offered this cycle
//   occupancy  out  number of held beats, 0..2
//   stall_cnt  out  saturating count of stalled output cycles
//   stall_clr  in   synchronous clear of stall_cnt
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int CTRL_W  = 16,
    parameter int DATA_W  = 133,
    parameter bit SKID_EN = 1'b1,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [DATA_W-1:0]  out_data,
    input  logic               flush,
    output logic [1:0]         occupancy,
    output logic [COUNT_W-1:0] stall_cnt,
    input  logic               stall_clr
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic               r_main_valid;
    logic [CTRL_W-1:0]  r_main_ctrl;
    logic [DATA_W-1:0]  r_main_data;
    logic               r_skid_valid;
    logic [CTRL_W-1:0]  r_skid_ctrl;
    logic [DATA_W-1:0]  r_skid_data;
    logic [1:0]         r_occ;
    logic [COUNT_W-1:0] r_stall_cnt;

    // -----------------------------------------------------------------------
    // Handshake and next-state wires
    // -----------------------------------------------------------------------
    logic               w_in_ready;
    logic               w_accept;
    logic               w_consume;
    logic               w_stall;

    logic               w_main_valid_nxt;
    logic [CTRL_W-1:0]  w_main_ctrl_nxt;
    logic [DATA_W-1:0]  w_main_data_nxt;
    logic               w_skid_valid_nxt;
    logic [CTRL_W-1:0]  w_skid_ctrl_nxt;
    logic [DATA_W-1:0]  w_skid_data_nxt;

    // Saturating increment: holds at all-ones instead of wrapping to zero.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        if (v == {COUNT_W{1'b1}}) begin
            return v;
        end
        return v + COUNT_W'(1);
    endfunction

    // Beat count from the two entry valid bits.
    function automatic logic [1:0] count_beats(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // -----------------------------------------------------------------------
    // Ready generation
    // -----------------------------------------------------------------------
    generate
        if (SKID_EN) begin : g_skid_ready
            // The skid entry is the only thing that can refuse a beat, so
            // ready is simply "skid is free" and comes straight from a flop.
            assign w_in_ready = !r_skid_valid;
        end else begin : g_single_ready
            // A full single entry can take a new beat only in the same edge
            // that the downstream drains it.
            assign w_in_ready = !r_main_valid || out_ready;
        end
    endgenerate

    assign w_accept  = in_valid && w_in_ready;
    assign w_consume = r_main_valid && out_ready;
    assign w_stall   = r_main_valid && !out_ready;

    // -----------------------------------------------------------------------
    // Entry next-state
    // -----------------------------------------------------------------------
    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_ctrl_nxt  = r_main_ctrl;
        w_main_data_nxt  = r_main_data;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_ctrl_nxt  = r_skid_ctrl;
        w_skid_data_nxt  = r_skid_data;

        if (flush) begin
            // Kill everything, including a beat offered this same edge.
            // Data slices are left as they are; only control is zeroed.
            w_main_valid_nxt = 1'b0;
            w_main_ctrl_nxt  = '0;
            w_skid_valid_nxt = 1'b0;
        end else if (r_skid_valid) begin
            // in_ready is low here, so no new beat can arrive; the only
            // movement is the older skid beat promoting into MAIN.
            if (w_consume) begin
                w_main_valid_nxt = 1'b1;
                w_main_ctrl_nxt  = r_skid_ctrl;
                w_main_data_nxt  = r_skid_data;
                w_skid_valid_nxt = 1'b0;
            end
        end else if (!r_main_valid || w_consume) begin
            // MAIN is free after this edge: fill it or turn it into a bubble.
            if (w_accept) begin
                w_main_valid_nxt = 1'b1;
                w_main_ctrl_nxt  = in_ctrl;
                w_main_data_nxt  = in_data;
            end else begin
                w_main_valid_nxt = 1'b0;
                w_main_ctrl_nxt  = '0;
            end
        end else if (w_accept && SKID_EN) begin
            // MAIN is stalled and still full: park the new beat in SKID.
            w_skid_valid_nxt = 1'b1;
            w_skid_ctrl_nxt  = in_ctrl;
            w_skid_data_nxt  = in_data;
        end
    end

    // -----------------------------------------------------------------------
    // Entry registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_data  <= '0;
            r_occ        <= 2'd0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_main_ctrl  <= w_main_ctrl_nxt;
            r_main_data  <= w_main_data_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_ctrl  <= w_skid_ctrl_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_occ        <= count_beats(w_main_valid_nxt, w_skid_valid_nxt);
        end
    end

    // -----------------------------------------------------------------------
    // Stall counter
    // -----------------------------------------------------------------------
    // Clear wins over an increment in the same edge; flush has no effect.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (stall_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign in_ready  = w_in_ready;
    assign out_valid = r_main_valid;
    assign out_ctrl  = r_main_ctrl;
    assign out_data  = r_main_data;
    assign occupancy = r_occ;
    assign stall_cnt = r_stall_cnt;

    // -----------------------------------------------------------------------
    // Structural invariants
    // -----------------------------------------------------------------------
    a_bubble_ctrl_zero : assert property (
        @(posedge clk) disable iff (!rst) !r_main_valid |-> (r_main_ctrl == '0));

    a_occ_matches_valid : assert property (
        @(posedge clk) disable iff (!rst) (r_occ != 2'd0) == r_main_valid);

    a_skid_behind_main : assert property (
        @(posedge clk) disable iff (!rst) r_skid_valid |-> r_main_valid);

    a_skid_unused : assert property (
        @(posedge clk) disable iff (!rst) !SKID_EN |-> !r_skid_valid);

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int CTRL_W  = 16;
    localparam int DATA_W  = 133;
    localparam int COUNT_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Main instance (SKID_EN=1, COUNT_W=16)
    logic               m_in_valid, m_in_ready, m_out_valid, m_out_ready;
    logic               m_flush, m_stall_clr;
    logic [CTRL_W-1:0]  m_in_ctrl, m_out_ctrl;
    logic [DATA_W-1:0]  m_in_data, m_out_data;
    logic [1:0]         m_occ;
    logic [COUNT_W-1:0] m_stall_cnt;

    // Narrow-counter instance sharing the main inputs (COUNT_W=3)
    logic               c_in_ready, c_out_valid;
    logic [CTRL_W-1:0]  c_out_ctrl;
    logic [DATA_W-1:0]  c_out_data;
    logic [1:0]         c_occ;
    logic [2:0]         c_stall_cnt;

    // Single-entry instance (SKID_EN=0)
    logic               z_in_valid, z_in_ready, z_out_valid, z_out_ready;
    logic               z_flush, z_stall_clr;
    logic [CTRL_W-1:0]  z_in_ctrl, z_out_ctrl;
    logic [DATA_W-1:0]  z_in_data, z_out_data;
    logic [1:0]         z_occ;
    logic [COUNT_W-1:0] z_stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID_EN(1'b1), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .in_ctrl(m_in_ctrl), .in_data(m_in_data),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out_ctrl(m_out_ctrl), .out_data(m_out_data),
        .flush(m_flush), .occupancy(m_occ), .stall_cnt(m_stall_cnt), .stall_clr(m_stall_clr)
    );

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID_EN(1'b1), .COUNT_W(3)) dut_cnt3 (
        .clk(clk), .rst(rst),
        .in_valid(m_in_valid), .in_ready(c_in_ready), .in_ctrl(m_in_ctrl), .in_data(m_in_data),
        .out_valid(c_out_valid), .out_ready(m_out_ready), .out_ctrl(c_out_ctrl), .out_data(c_out_data),
        .flush(m_flush), .occupancy(c_occ), .stall_cnt(c_stall_cnt), .stall_clr(m_stall_clr)
    );

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID_EN(1'b0), .COUNT_W(COUNT_W)) dut_noskid (
        .clk(clk), .rst(rst),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_ctrl(z_in_ctrl), .in_data(z_in_data),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_ctrl(z_out_ctrl), .out_data(z_out_data),
        .flush(z_flush), .occupancy(z_occ), .stall_cnt(z_stall_cnt), .stall_clr(z_stall_clr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst        = 1'b0;
        m_in_valid = 1'b1;
        m_in_ctrl  = 16'h0055;
        m_in_data  = DATA_W'(8'h55);
        z_in_valid = 1'b1;
        z_in_ctrl  = 16'h0066;
        z_in_data  = DATA_W'(8'h66);
        tick();
        tick();
        checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0h expected 0", m_out_valid); end
        checks++; if (m_out_ctrl !== 16'h0000) begin errors++; $display("FAIL reset_out_ctrl: got %0h expected 0", m_out_ctrl); end
        checks++; if (m_out_data !== DATA_W'(0)) begin errors++; $display("FAIL reset_out_data: got %0h expected 0", m_out_data); end
        checks++; if (m_occ !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", m_occ); end
        checks++; if (m_stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", m_stall_cnt); end
        checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0h expected 1", m_in_ready); end
        checks++; if (z_in_ready !== 1'b1) begin errors++; $display("FAIL reset_noskid_in_ready: got %0h expected 1", z_in_ready); end
        checks++; if (z_out_valid !== 1'b0) begin errors++; $display("FAIL reset_noskid_out_valid: got %0h expected 0", z_out_valid); end
        checks++; if (c_stall_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt3: got %0d expected 0", c_stall_cnt); end
        rst        = 1'b1;
        m_in_valid = 1'b0;
        z_in_valid = 1'b0;
        tick();
        checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_out_valid: got %0h expected 0", m_out_valid); end
    endtask

    task automatic test_stream;
        m_out_ready = 1'b1;
        m_in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            m_in_data = DATA_W'(i);
            m_in_ctrl = CTRL_W'(16'h0100 + i);
            tick();
            checks++; if (m_out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %0h expected 1", i, m_out_valid); end
            checks++; if (m_out_data !== DATA_W'(i)) begin errors++; $display("FAIL stream_data[%0d]: got %0h expected %0h", i, m_out_data, i); end
            checks++; if (m_out_ctrl !== CTRL_W'(16'h0100 + i)) begin errors++; $display("FAIL stream_ctrl[%0d]: got %0h expected %0h", i, m_out_ctrl, 16'h0100 + i); end
            checks++; if (m_occ !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d]: got %0d expected 1", i, m_occ); end
        end
        m_in_valid = 1'b0;
        tick();
        checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid: got %0h expected 0", m_out_valid); end
        checks++; if (m_out_ctrl !== 16'h0000) begin errors++; $display("FAIL stream_bubble_ctrl: got %0h expected 0", m_out_ctrl); end
        checks++; if (m_out_data !== DATA_W'(8)) begin errors++; $display("FAIL stream_bubble_data_held: got %0h expected 8", m_out_data); end
        checks++; if (m_occ !== 2'd0) begin errors++; $display("FAIL stream_drain_occ: got %0d expected 0", m_occ); end
        checks++; if (m_stall_cnt !== 16'd0) begin errors++; $display("FAIL stream_stall_cnt: got %0d expected 0", m_stall_cnt); end
    endtask

    task automatic test_back_pressure;
        m_out_ready = 1'b0;
        m_in_valid  = 1'b1;
        m_in_data   = DATA_W'(8'hA);
        m_in_ctrl   = 16'h000A;
        tick();
        checks++; if (m_out_data !== DATA_W'(8'hA)) begin errors++; $display("FAIL bp_main_data: got %0h expected a", m_out_data); end
        checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one_held: got %0h expected 1", m_in_ready); end
        m_in_data = DATA_W'(8'hB);
        m_in_ctrl = 16'h000B;
        tick();
        checks++; if (m_occ !== 2'd2) begin errors++; $display("FAIL bp_occ_two: got %0d expected 2", m_occ); end
        checks++; if (m_in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %0h expected 0", m_in_ready); end
        checks++; if (m_out_data !== DATA_W'(8'hA)) begin errors++; $display("FAIL bp_main_kept: got %0h expected a", m_out_data); end
        checks++; if (m_stall_cnt !== 16'd1) begin errors++; $display("FAIL bp_stall_cnt1: got %0d expected 1", m_stall_cnt); end
        // 0xC is offered while the stage is full and must never be taken.
        m_in_data = DATA_W'(8'hC);
        m_in_ctrl = 16'h000C;
        tick();
        checks++; if (m_occ !== 2'd2) begin errors++; $display("FAIL bp_occ_hold: got %0d expected 2", m_occ); end
        checks++; if (m_stall_cnt !== 16'd2) begin errors++; $display("FAIL bp_stall_cnt2: got %0d expected 2", m_stall_cnt); end
        m_in_valid  = 1'b0;
        m_out_ready = 1'b1;
        tick();
        checks++; if (m_out_data !== DATA_W'(8'hB)) begin errors++; $display("FAIL bp_skid_promote_data: got %0h expected b", m_out_data); end
        checks++; if (m_out_ctrl !== 16'h000B) begin errors++; $display("FAIL bp_skid_promote_ctrl: got %0h expected b", m_out_ctrl); end
        checks++; if (m_occ !== 2'd1) begin errors++; $display("FAIL bp_occ_one: got %0d expected 1", m_occ); end
        checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %0h expected 1", m_in_ready); end
        tick();
        checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty_valid: got %0h expected 0", m_out_valid); end
        checks++; if (m_out_data !== DATA_W'(8'hB)) begin errors++; $display("FAIL bp_no_extra_beat: got %0h expected b", m_out_data); end
        checks++; if (m_occ !== 2'd0) begin errors++; $display("FAIL bp_empty_occ: got %0d expected 0", m_occ); end
    endtask

    task automatic test_flush;
        m_out_ready = 1'b0;
        m_in_valid  = 1'b1;
        m_in_data   = DATA_W'(8'hD);
        m_in_ctrl   = 16'h000D;
        tick();
        m_in_data = DATA_W'(8'hE);
        m_in_ctrl = 16'h000E;
        tick();
        checks++; if (m_occ !== 2'd2) begin errors++; $display("FAIL flush_pre_occ: got %0d expected 2", m_occ); end
        m_flush   = 1'b1;
        m_in_data = DATA_W'(8'hF);
        m_in_ctrl = 16'hFFFF;
        tick();
        checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0h expected 0", m_out_valid); end
        checks++; if (m_out_ctrl !== 16'h0000) begin errors++; $display("FAIL flush_ctrl: got %0h expected 0", m_out_ctrl); end
        checks++; if (m_occ !== 2'd0) begin errors++; $display("FAIL flush_occ: got %0d expected 0", m_occ); end
        checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %0h expected 1", m_in_ready); end
        checks++; if (m_stall_cnt !== 16'd4) begin errors++; $display("FAIL flush_stall_untouched: got %0d expected 4", m_stall_cnt); end
        m_flush     = 1'b0;
        m_in_valid  = 1'b0;
        m_out_ready = 1'b1;
        tick();
        checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL flush_beat_dropped: got %0h expected 0", m_out_valid); end
        // Flush while in_ready=1: the offered beat must still be dropped.
        m_in_valid = 1'b1;
        m_in_data  = DATA_W'(8'h21);
        m_in_ctrl  = 16'h0021;
        tick();
        checks++; if (m_out_data !== DATA_W'(8'h21)) begin errors++; $display("FAIL flush2_pre_data: got %0h expected 21", m_out_data); end
        checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL flush2_pre_ready: got %0h expected 1", m_in_ready); end
        m_flush   = 1'b1;
        m_in_data = DATA_W'(8'h22);
        m_in_ctrl = 16'hFFFF;
        tick();
        checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL flush2_valid: got %0h expected 0", m_out_valid); end
        checks++; if (m_out_ctrl !== 16'h0000) begin errors++; $display("FAIL flush2_ctrl: got %0h expected 0", m_out_ctrl); end
        checks++; if (m_out_data !== DATA_W'(8'h21)) begin errors++; $display("FAIL flush2_data_held: got %0h expected 21", m_out_data); end
        m_flush    = 1'b0;
        m_in_valid = 1'b0;
        tick();
        checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL flush2_beat_dropped: got %0h expected 0", m_out_valid); end
        checks++; if (m_stall_cnt !== 16'd4) begin errors++; $display("FAIL flush2_stall_cnt: got %0d expected 4", m_stall_cnt); end
    endtask

    task automatic test_stall_counter;
        m_stall_clr = 1'b1;
        tick();
        checks++; if (m_stall_cnt !== 16'd0) begin errors++; $display("FAIL cnt_clear_idle: got %0d expected 0", m_stall_cnt); end
        checks++; if (c_stall_cnt !== 3'd0) begin errors++; $display("FAIL cnt3_clear_idle: got %0d expected 0", c_stall_cnt); end
        m_stall_clr = 1'b0;
        m_out_ready = 1'b0;
        m_in_valid  = 1'b1;
        m_in_data   = DATA_W'(8'h30);
        m_in_ctrl   = 16'h0030;
        tick();
        m_in_valid = 1'b0;
        checks++; if (m_stall_cnt !== 16'd0) begin errors++; $display("FAIL cnt_first_accept: got %0d expected 0", m_stall_cnt); end
        repeat (7) tick();
        checks++; if (c_stall_cnt !== 3'd7) begin errors++; $display("FAIL cnt3_at_max: got %0d expected 7", c_stall_cnt); end
        checks++; if (m_stall_cnt !== 16'd7) begin errors++; $display("FAIL cnt_seven: got %0d expected 7", m_stall_cnt); end
        repeat (3) tick();
        checks++; if (c_stall_cnt !== 3'd7) begin errors++; $display("FAIL cnt3_saturated: got %0d expected 7", c_stall_cnt); end
        checks++; if (m_stall_cnt !== 16'd10) begin errors++; $display("FAIL cnt_ten: got %0d expected 10", m_stall_cnt); end
        m_stall_clr = 1'b1;
        tick();
        checks++; if (c_stall_cnt !== 3'd0) begin errors++; $display("FAIL cnt3_clear_in_stall: got %0d expected 0", c_stall_cnt); end
        checks++; if (m_stall_cnt !== 16'd0) begin errors++; $display("FAIL cnt_clear_in_stall: got %0d expected 0", m_stall_cnt); end
        m_stall_clr = 1'b0;
        tick();
        checks++; if (m_stall_cnt !== 16'd1) begin errors++; $display("FAIL cnt_resume: got %0d expected 1", m_stall_cnt); end
        m_out_ready = 1'b1;
        tick();
        checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL cnt_drain_valid: got %0h expected 0", m_out_valid); end
        checks++; if (m_stall_cnt !== 16'd1) begin errors++; $display("FAIL cnt_no_inc_on_consume: got %0d expected 1", m_stall_cnt); end
    endtask

    task automatic test_reset_mid;
        m_out_ready = 1'b0;
        m_in_valid  = 1'b1;
        m_in_data   = DATA_W'(8'h41);
        m_in_ctrl   = 16'h0041;
        tick();
        m_in_data = DATA_W'(8'h42);
        tick();
        checks++; if (m_occ !== 2'd2) begin errors++; $display("FAIL rstmid_pre_occ: got %0d expected 2", m_occ); end
        rst       = 1'b0;
        m_flush   = 1'b1;
        m_in_data = DATA_W'(8'h43);
        tick();
        checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %0h expected 0", m_out_valid); end
        checks++; if (m_out_data !== DATA_W'(0)) begin errors++; $display("FAIL rstmid_data: got %0h expected 0", m_out_data); end
        checks++; if (m_occ !== 2'd0) begin errors++; $display("FAIL rstmid_occ: got %0d expected 0", m_occ); end
        checks++; if (m_stall_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_stall_cnt: got %0d expected 0", m_stall_cnt); end
        checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %0h expected 1", m_in_ready); end
        rst        = 1'b1;
        m_flush    = 1'b0;
        m_in_valid = 1'b0;
        tick();
        checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after_valid: got %0h expected 0", m_out_valid); end
    endtask

    task automatic test_no_skid;
        z_out_ready = 1'b0;
        z_in_valid  = 1'b1;
        z_in_data   = DATA_W'(8'h40);
        z_in_ctrl   = 16'h0040;
        tick();
        checks++; if (z_out_data !== DATA_W'(8'h40)) begin errors++; $display("FAIL ns_first_data: got %0h expected 40", z_out_data); end
        checks++; if (z_occ !== 2'd1) begin errors++; $display("FAIL ns_first_occ: got %0d expected 1", z_occ); end
        z_in_data = DATA_W'(8'h41);
        z_in_ctrl = 16'h0041;
        #1;
        checks++; if (z_in_ready !== 1'b0) begin errors++; $display("FAIL ns_ready_low: got %0h expected 0", z_in_ready); end
        tick();
        checks++; if (z_out_data !== DATA_W'(8'h40)) begin errors++; $display("FAIL ns_hold_data: got %0h expected 40", z_out_data); end
        checks++; if (z_occ !== 2'd1) begin errors++; $display("FAIL ns_occ_max_one: got %0d expected 1", z_occ); end
        z_out_ready = 1'b1;
        #1;
        checks++; if (z_in_ready !== 1'b1) begin errors++; $display("FAIL ns_ready_comb: got %0h expected 1", z_in_ready); end
        tick();
        checks++; if (z_out_data !== DATA_W'(8'h41)) begin errors++; $display("FAIL ns_replace_data: got %0h expected 41", z_out_data); end
        checks++; if (z_out_ctrl !== 16'h0041) begin errors++; $display("FAIL ns_replace_ctrl: got %0h expected 41", z_out_ctrl); end
        for (int i = 0; i < 3; i++) begin
            z_in_data = DATA_W'(8'h50 + i);
            z_in_ctrl = CTRL_W'(16'h0050 + i);
            tick();
            checks++; if (z_out_data !== DATA_W'(8'h50 + i)) begin errors++; $display("FAIL ns_stream[%0d]: got %0h expected %0h", i, z_out_data, 8'h50 + i); end
        end
        z_in_valid = 1'b0;
        tick();
        checks++; if (z_out_valid !== 1'b0) begin errors++; $display("FAIL ns_drain_valid: got %0h expected 0", z_out_valid); end
        checks++; if (z_out_ctrl !== 16'h0000) begin errors++; $display("FAIL ns_drain_ctrl: got %0h expected 0", z_out_ctrl); end
        checks++; if (z_occ !== 2'd0) begin errors++; $display("FAIL ns_drain_occ: got %0d expected 0", z_occ); end
        checks++; if (z_stall_cnt !== 16'd1) begin errors++; $display("FAIL ns_stall_cnt: got %0d expected 1", z_stall_cnt); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        m_in_valid  = 1'b0;
        m_in_ctrl   = '0;
        m_in_data   = '0;
        m_out_ready = 1'b0;
        m_flush     = 1'b0;
        m_stall_clr = 1'b0;
        z_in_valid  = 1'b0;
        z_in_ctrl   = '0;
        z_in_data   = '0;
        z_out_ready = 1'b0;
        z_flush     = 1'b0;
        z_stall_clr = 1'b0;

        test_reset();
        test_stream();
        test_back_pressure();
        test_flush();
        test_stall_counter();
        test_reset_mid();
        test_no_skid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
